// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor with valid/ready handshakes.
// One GROUP-bit look-ahead slice is resolved per stage; the carry is registered between stages.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NG = WIDTH / GROUP;

  typedef logic [GROUP-1:0] slice_t;

  if (GROUP == 0 || (WIDTH % GROUP) != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  // Flat sum-of-products look-ahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
  function automatic logic [GROUP:0] cla_carries(input slice_t p, input slice_t g, input logic ci);
    logic [GROUP:0] c;
    logic           t;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(GROUP); i++) begin
      t = ci;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

  logic adv;
  logic last_valid;

  // Global stall: every stage holds whenever the output slot is full and not taken.
  assign adv       = ~last_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = last_valid;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    slice_t         a_in [NG];
    slice_t         b_in [NG];
    slice_t         s_in [NG];
    logic           c_in;
    logic           v_in;
    slice_t         p;
    slice_t         g;
    slice_t         s_new;
    logic [GROUP:0] c;
    logic           v_q;
    logic           c_q;
    slice_t         s_q [NG];

    if (k == 0) begin : g_src
      // Operand preparation: subtraction is A + ~B + 1.
      always_comb begin
        for (int j = 0; j < int'(NG); j++) begin
          a_in[j] = a[j*GROUP +: GROUP];
          b_in[j] = sub ? ~b[j*GROUP +: GROUP] : b[j*GROUP +: GROUP];
          s_in[j] = '0;
        end
      end
      assign c_in = sub | cin;
      assign v_in = in_valid;
    end else begin : g_src
      assign a_in = g_stage[k-1].g_opd.a_q;
      assign b_in = g_stage[k-1].g_opd.b_q;
      assign s_in = g_stage[k-1].s_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
    end

    always_comb begin
      p     = a_in[k] ^ b_in[k];
      g     = a_in[k] & b_in[k];
      c     = cla_carries(p, g, c_in);
      s_new = p ^ c[GROUP-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '{default: '0};
      end else if (adv) begin
        v_q <= v_in;
        c_q <= c[GROUP];
        for (int j = 0; j < int'(NG); j++) begin
          s_q[j] <= (j == k) ? s_new : s_in[j];
        end
      end
    end

    if (k < NG - 1) begin : g_opd
      slice_t a_q [NG];
      slice_t b_q [NG];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '{default: '0};
          b_q <= '{default: '0};
        end else if (adv) begin
          a_q <= a_in;
          b_q <= b_in;
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Signed overflow: carry into MSB differs from carry out of MSB.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= c[GROUP] ^ c[GROUP-1];
        end
      end
    end
  end

  assign last_valid = g_stage[NG-1].v_q;
  assign cout       = g_stage[NG-1].c_q;
  assign ovf        = g_stage[NG-1].g_last.ovf_q;

  always_comb begin
    sum = '0;
    for (int j = 0; j < int'(NG); j++) begin
      sum[j*GROUP +: GROUP] = g_stage[NG-1].s_q[j];
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: 16/4 main instance plus 16/16 and 32/8
// instances sharing the stimulus, each with its own in-order scoreboard.
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, cin, sub;
  logic [31:0] a32, b32;

  logic        rdy0, ov0, co0, of0;
  logic [15:0] s0;
  logic        rdy1, ov1, co1, of1;
  logic [15:0] s1;
  logic        rdy2, ov2, co2, of2;
  logic [31:0] s2;

  logic [17:0] exp0;
  logic [33:0] m0, m1, m2;
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [33:0] q2[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .a(a32[15:0]), .b(b32[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(of0));

  pipelined_cla_adder #(.WIDTH(16), .GROUP(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .a(a32[15:0]), .b(b32[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1));

  pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .a(a32), .b(b32), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2), .ovf(of2));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl[11];

  // Reference: {cout, ovf, sum} for a w-bit add/sub, computed with plain integer arithmetic.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s);
    logic [32:0] r;
    logic [31:0] m, yy, xx, sm;
    logic        ov;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xx = x & m;
    yy = (s ? ~y : y) & m;
    r  = {1'b0, xx} + {1'b0, yy} + {32'd0, (s | ci)};
    sm = r[31:0] & m;
    ov = (xx[w-1] == yy[w-1]) && (sm[w-1] != xx[w-1]);
    return {r[w], ov, sm};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic extra(input string nm, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected result %h with empty scoreboard (t=%0t)", nm, act, $time);
  endtask

  task automatic upd_exp0();
    logic [33:0] r;
    r    = model(16, a32, b32, cin, sub);
    exp0 = {r[33:32], r[15:0]};
  endtask

  task automatic set_beat(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s);
    a32 = {16'h0000, x};
    b32 = {16'h0000, y};
    cin = ci;
    sub = s;
    upd_exp0();
  endtask

  // Scoreboards: push on accept, pop on emit; sampled mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid && rdy0) q0.push_back(exp0);
      if (ov0 && out_ready) begin
        if (q0.size() == 0) extra("sb16x4", 64'({co0, of0, s0}));
        else chk("sb16x4", 64'({co0, of0, s0}), 64'(q0.pop_front()));
      end
      if (in_valid && rdy1) begin
        m1 = model(16, a32, b32, cin, sub);
        q1.push_back({m1[33:32], m1[15:0]});
      end
      if (ov1 && out_ready) begin
        if (q1.size() == 0) extra("sb16x16", 64'({co1, of1, s1}));
        else chk("sb16x16", 64'({co1, of1, s1}), 64'(q1.pop_front()));
      end
      if (in_valid && rdy2) begin
        m2 = model(32, a32, b32, cin, sub);
        q2.push_back(m2);
      end
      if (ov2 && out_ready) begin
        if (q2.size() == 0) extra("sb32x8", 64'({co2, of2, s2}));
        else chk("sb32x8", 64'({co2, of2, s2}), 64'(q2.pop_front()));
      end
    end
  end

  // In-flight beats are discarded by reset, so their expectations go too.
  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
    q2.delete();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish within time limit, got t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx, ghost, acc, cyc;

    tbl[0]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[10] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_beat(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ov0), 64'(0));
    chk("rst_sum", 64'(s0), 64'(0));
    chk("rst_cout", 64'(co0), 64'(0));
    chk("rst_ovf", 64'(of0), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rdy_after_rst", 64'(rdy0), 64'(1));

    // Single add: accepted on cycle 0, visible on cycle 4 only.
    @(posedge clk); #1;
    set_beat(16'h1234, 16'h4321, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("latency_valid_c%0d", c), 64'(ov0), 64'(c == 4));
    end
    chk("add_sum", 64'(s0), 64'(16'h5555));
    chk("add_cout", 64'(co0), 64'(0));
    chk("add_ovf", 64'(of0), 64'(0));
    @(posedge clk); #1;

    // Table vectors streamed back to back with the output always ready.
    for (int i = 0; i < 11; i++) begin
      set_beat(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      exp0     = {tbl[i].cout, tbl[i].ovf, tbl[i].sum};
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("tbl_drain", 64'(q0.size()), 64'(0));

    // Backpressure: out_ready low on cycles 5..9 while 8 beats stream in.
    idx = 0;
    for (int c = 0; c < 25; c++) begin
      out_ready = !(c >= 5 && c <= 9);
      if (idx < 8) begin
        set_beat(16'(idx), 16'(idx * 3), 1'b0, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 9) begin
        chk($sformatf("bp_in_ready_c%0d", c), 64'(rdy0), 64'(0));
        chk($sformatf("bp_hold_valid_c%0d", c), 64'(ov0), 64'(1));
        chk($sformatf("bp_hold_sum_c%0d", c), 64'({co0, of0, s0}), 64'(18'h00004));
      end
      if (in_valid && rdy0) idx++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_accepted", 64'(idx), 64'(8));
    chk("bp_drain", 64'(q0.size()), 64'(0));

    // Reset between clock edges with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      set_beat(16'(100 + i), 16'(7 * i), 1'b0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 64'(ov0), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(ov0), 64'(0));
    chk("async_rst_sum", 64'(s0), 64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ghost = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov0) ghost++;
    end
    chk("no_ghost_after_rst", 64'(ghost), 64'(0));

    // Random regression with random backpressure and bubbles.
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      a32       = $urandom;
      b32       = $urandom;
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      upd_exp0();
      #1;
      if (in_valid && rdy0) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_accepted", 64'(acc), 64'(10000));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_16x4", 64'(q0.size()), 64'(0));
    chk("drain_16x16", 64'(q1.size()), 64'(0));
    chk("drain_32x8", 64'(q2.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor. It generalises our 4-bit CLA to WIDTH bits.
- Operands are split into GROUP-bit look-ahead slices, and one slice is resolved per pipeline stage. The carry ripples between stages through registers.
- Valid/ready handshakes on input and output let the block drop into streaming datapaths such as accumulators and DSP chains, with full backpressure.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of GROUP; any other value is an elaboration error.
- GROUP, 4, bits per CLA slice. Each slice uses generate/propagate look-ahead internally, with no ripple inside a slice.
- NG, WIDTH/GROUP (derived, not overridable), number of slices, which equals the number of pipeline stages.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in (used only when sub=0)
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1, cin ignored)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB; for subtraction 1 = no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: asynchronous on rst_n low.
  - All stage valid bits, out_valid, sum, cout and ovf go to 0.
  - in_ready goes to 1 immediately after reset releases.
  - In-flight beats are discarded, never emitted.
- Operand preparation, at acceptance:
  - Effective B is b when sub=0, ~b when sub=1.
  - Effective carry-in is cin when sub=0, 1 when sub=1.
- Stage k (k = 0..NG-1):
  - Computes P = A^B and G = A&B for slice k, plus the slice's carries via full look-ahead equations from the registered carry of stage k-1 (stage 0 uses effective cin).
  - Registers the slice's sum bits, the slice carry-out, the remaining upper operand slices and the already-resolved lower sum bits.
- Last stage outputs:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
- Latency and throughput:
  - A beat accepted on cycle t (in_valid & in_ready) appears with out_valid=1 on cycle t+NG when there is no stall.
  - Throughput is one beat per cycle.
- Flow control is a global stall:
  - adv = ~out_valid | out_ready, and in_ready = adv.
  - When adv=0, every stage register holds, including data, valid and carry.
  - When adv=1, all stages shift by one. An empty slot shifts in as a bubble (valid=0), and its data does not care.
  - Bubbles are not collapsed.
- Output hold: while out_valid=1 and out_ready=0, sum/cout/ovf stay stable. A transfer occurs on out_valid & out_ready.
- Simultaneous events: accept and emit in the same cycle are legal. The pipeline shifts, so a full pipeline sustains one beat per cycle with out_ready held high.
- Stability rule: a, b, cin and sub are sampled only on acceptance, so their value while in_ready=0 is irrelevant.
- Wrap-around: sums are modulo 2^WIDTH, and the carry is reported only on cout.
- NG=1 (GROUP=WIDTH) is legal and gives latency 1.
- No combinational path from in_valid to in_ready. The only combinational path is out_ready to in_ready.

Test Plan:
All scenarios use WIDTH=16 and GROUP=4, so NG=4.
1. Reset then single add: a=16'h1234, b=16'h4321, cin=0, sub=0 at cycle 0 -> out_valid on cycle 4, sum=16'h5555, cout=0, ovf=0. out_valid stays 0 on cycles 1-3.
2. Full carry chain: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0. Then a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
3. Subtract: a=16'h0005, b=16'h0007, sub=1, cin=1 (must be ignored) -> sum=16'hFFFE, cout=0 (borrow), ovf=0. Then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
4. Backpressure: stream 8 back-to-back beats (a=i, b=i*3) with out_ready=0 from cycle 5 to cycle 9.
   - in_ready=0 during the stall.
   - Output holds sum=16'h0004 (beat 1) stable.
   - After release all 8 results emerge in order (sum=4*i), with no loss or duplication.
5. Reset mid-operation: accept 3 beats, assert rst_n=0 asynchronously between clock edges -> out_valid drops to 0 immediately, and none of the 3 results ever appear after release.
6. Random regression: 10k beats with random out_ready and in_valid, compared against a+(sub?~b:b)+(sub?1:cin) -> every sum/cout/ovf matches in order. Repeat with GROUP=16 (NG=1, latency 1) and WIDTH=32/GROUP=8.
